// File: rtl/uart_tx_drain.sv
// UART 8N1 transmitter that drains the bridge byte FIFO, one pop per frame.
// Optional even parity (8E1) is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_fifo_data,
  output logic       o_fifo_rd_en,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP   = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              hold_q;
  logic              bit_end;
  logic [BAUD_W-1:0] baud_inc;

  assign bit_end  = (baud_q == BAUD_LAST);
  assign baud_inc = bit_end ? '0 : baud_q + 1'b1;

`ifdef UART_TX_PARITY_EN
  logic par_q;
  always_ff @(posedge i_clk) begin
    if (i_reset)                par_q <= 1'b0;
    else if (state_q == S_FETCH) par_q <= ^i_fifo_data;
  end
`endif

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    o_fifo_rd_en = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // hold_q keeps the cycle after a reset pop-free as well
        if (i_enable && !i_fifo_empty && !i_reset && !hold_q) begin
          o_fifo_rd_en = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        shift_d = i_fifo_data;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        baud_d = baud_inc;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        baud_d = baud_inc;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        baud_d = baud_inc;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        baud_d = baud_inc;
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            o_done  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the next state so o_tx never glitches
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      hold_q  <= 1'b0;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != S_IDLE) || o_fifo_rd_en;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a small FIFO model and a byte scoreboard.
// Define UART_TX_PARITY_EN for both files to exercise the 8E1 frame.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 44;
`else
  localparam int FL = 40;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       rd_en, tx, busy, done;

  logic [7:0] mem [0:31];
  int wr_ptr = 0, rd_ptr = 0;
  int cyc = 0, pop_cnt = 0, last_pop_cyc = 0, underflow_cnt = 0;
  int n_checks = 0, n_pass = 0;
  logic [7:0] exp_q[$];

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd_en(rd_en), .o_tx(tx), .o_busy(busy), .o_done(done)
  );

  // clock / FIFO model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      fifo_data    <= mem[rd_ptr % 32];
      rd_ptr       <= rd_ptr + 1;
      pop_cnt      <= pop_cnt + 1;
      last_pop_cyc <= cyc;
      if (rd_ptr == wr_ptr) underflow_cnt <= underflow_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b, input bit expect_tx);
    mem[wr_ptr % 32] = b;
    wr_ptr = wr_ptr + 1;
    if (expect_tx) exp_q.push_back(b);
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < 4)  return 1'b0;
    if (k < 36) return b[(k - 4) / 4];
`ifdef UART_TX_PARITY_EN
    if (k < 40) return ^b;
`endif
    return 1'b1;
  endfunction

  // Waits for a start bit, then checks every cycle of the frame against the next expected byte
  task automatic check_frame(output int start_cyc);
    logic [7:0] b, rx;
    int errs, berr, derr;
    bit found;
    found = 0;
    start_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1; break; end
    end
    check("frame_start", found, 1);
    if (!found) return;
    start_cyc = cyc;
    check("pop_to_start", cyc - last_pop_cyc, 3);
    b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    rx = 8'h00; errs = 0; berr = 0; derr = 0;
    for (int k = 0; k < FL; k++) begin
      if (k > 0) @(negedge clk);
      if (tx !== exp_tx(b, k)) errs++;
      if (busy !== 1'b1) berr++;
      if (done !== (k == FL - 1)) derr++;
      if (k >= 4 && k < 36 && (k % 4) == 2) rx[(k - 4) / 4] = tx;
    end
    check("frame_byte", rx, b);
    check("frame_bits", errs, 0);
    check("frame_busy", berr, 0);
    check("frame_done", derr, 0);
  endtask

  initial begin
    int s1, s2, s3, p0, errs, rd_seen;
    bit found;

    // reset
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single byte 0xA5
    p0 = pop_cnt;
    push(8'hA5, 1);
    enable = 1'b1;
    check_frame(s1);
    repeat (6) @(negedge clk);
    check("s1_pops", pop_cnt - p0, 1);
    check("s1_busy_idle", busy, 0);
    check("s1_tx_idle", tx, 1);

    // 2: back-to-back frames
    p0 = pop_cnt;
    push(8'h00, 1); push(8'hFF, 1); push(8'h3C, 1);
    check_frame(s1);
    check_frame(s2);
    check_frame(s3);
    check("s2_gap1", s2 - s1, FL + 3);
    check("s2_gap2", s3 - s2, FL + 3);
    repeat (6) @(negedge clk);
    check("s2_pops", pop_cnt - p0, 3);

    // 3: empty FIFO never popped
    errs = 0; rd_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_en !== 1'b0) rd_seen++;
      if (tx !== 1'b1) errs++;
    end
    check("s3_no_pop", rd_seen, 0);
    check("s3_tx_high", errs, 0);

    // 4: enable dropped mid-frame
    p0 = pop_cnt;
    push(8'h55, 1); push(8'h11, 1); push(8'h22, 1);
    fork
      check_frame(s1);
      begin repeat (10) @(negedge clk); enable = 1'b0; end
    join
    repeat (60) @(negedge clk);
    check("s4_pops", pop_cnt - p0, 1);
    check("s4_fifo_left", wr_ptr - rd_ptr, 2);
    check("s4_tx_idle", tx, 1);
    enable = 1'b1;
    check_frame(s1);
    check_frame(s2);

    // 5: reset during DATA of 0x81
    enable = 1'b0;
    push(8'h81, 0); push(8'h42, 1);
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin found = 1; break; end
    end
    check("s5_start", found, 1);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    p0 = pop_cnt;
    @(negedge clk);
    check("s5_tx", tx, 1);
    check("s5_busy", busy, 0);
    check("s5_rd_en", rd_en, 0);
    reset = 1'b0;
    check("s5_no_pop", pop_cnt - p0, 0);
    check_frame(s1);

    // 6: parity vectors (plain frames when parity is not compiled)
    push(8'h07, 1); push(8'h03, 1);
    check_frame(s1);
    check_frame(s2);

    repeat (10) @(negedge clk);
    check("underflow", underflow_cnt, 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
